// File: rtl/tipi_rpi_shift.sv
// tipi_rpi_shift: RPi serial link, resampled into clk, giving read access
// to the TI TD/TC bytes and write access to the RD/RC read-back bytes.
module tipi_rpi_shift #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ti_data_q,
    input  logic [7:0] ti_control_q,
    input  logic       r_clk,
    input  logic       r_le,
    input  logic [1:0] r_reg,
    input  logic       r_dout,
    output logic       r_din,
    output logic [7:0] rpi_rd,
    output logic [7:0] rpi_rc,
    output logic       xfer_done,
    output logic       xfer_err
);

    localparam int SW = 21;
    localparam int RW = $clog2(STABLE_CYCLES + 1) + 1;
    localparam logic [RW-1:0] RUN_MAX = RW'(STABLE_CYCLES);

    typedef enum logic {IDLE, ACTIVE} state_t;

    logic [SW-1:0] async_in;
    logic [SW-1:0] sync_q [SYNC_STAGES];
    logic [SW-1:0] sync_s;
    logic          r_clk_d;
    logic          r_le_d;
    logic          r_clk_s;
    logic          r_le_s;
    logic          r_dout_s;
    logic [1:0]    r_reg_s;

    logic [7:0]    ti_s      [2];
    logic [7:0]    ti_last   [2];
    logic [7:0]    ti_stable [2];
    logic [RW-1:0] ti_run    [2];
    logic [RW-1:0] run_n     [2];

    state_t     state;
    logic [1:0] sel;
    logic [7:0] shreg;
    logic [7:0] sh_n;
    logic [3:0] bitcnt;
    logic [3:0] cnt_n;
    logic       clk_rise;
    logic       le_rise;
    logic       le_fall;

    assign async_in = {ti_control_q, ti_data_q, r_dout, r_reg, r_le, r_clk};

    assign sync_s   = sync_q[SYNC_STAGES-1];
    assign r_clk_s  = sync_s[0];
    assign r_le_s   = sync_s[1];
    assign r_reg_s  = sync_s[3:2];
    assign r_dout_s = sync_s[4];
    assign ti_s[0]  = sync_s[12:5];
    assign ti_s[1]  = sync_s[20:13];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            r_clk_d <= 1'b0;
            r_le_d  <= 1'b0;
        end else begin
            sync_q[0] <= async_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            r_clk_d <= r_clk_s;
            r_le_d  <= r_le_s;
        end
    end

    // run length of identical synced samples, saturating at RUN_MAX
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            run_n[k] = RW'(1);
            if (ti_s[k] == ti_last[k])
                run_n[k] = (ti_run[k] == RUN_MAX) ? RUN_MAX
                                                   : ti_run[k] + RW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                ti_last[k]   <= '0;
                ti_run[k]    <= '0;
                ti_stable[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                ti_last[k] <= ti_s[k];
                ti_run[k]  <= run_n[k];
                if (run_n[k] >= RUN_MAX) ti_stable[k] <= ti_s[k];
            end
        end
    end

    assign clk_rise = r_clk_s & ~r_clk_d;
    assign le_rise  = r_le_s & ~r_le_d;
    assign le_fall  = ~r_le_s & r_le_d;

    always_comb begin
        sh_n  = shreg;
        cnt_n = bitcnt;
        if (clk_rise) begin
            sh_n  = {shreg[6:0], r_dout_s};
            cnt_n = (bitcnt == 4'd9) ? 4'd9 : bitcnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            sel       <= '0;
            shreg     <= '0;
            bitcnt    <= '0;
            r_din     <= 1'b0;
            rpi_rd    <= '0;
            rpi_rc    <= '0;
            xfer_done <= 1'b0;
            xfer_err  <= 1'b0;
        end else begin
            xfer_done <= 1'b0;
            r_din     <= (state == ACTIVE) ? shreg[7] : 1'b0;
            unique case (state)
                IDLE: begin
                    if (le_rise) begin
                        sel    <= r_reg_s;
                        bitcnt <= '0;
                        if (!r_reg_s[1]) shreg <= ti_stable[r_reg_s[0]];
                        state  <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    // a same-cycle clock edge is folded in before the commit
                    shreg  <= sh_n;
                    bitcnt <= cnt_n;
                    if (le_fall) begin
                        state <= IDLE;
                        if (cnt_n == 4'd8) begin
                            xfer_done <= 1'b1;
                            if (sel == 2'd2) rpi_rd <= sh_n;
                            if (sel == 2'd3) rpi_rc <= sh_n;
                        end else begin
                            xfer_err <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
